display_arbiter: RTL and testbench

Shares the single 8-digit seven-segment display driver among three requesters. The requesters are the live entry value (requester 0, the background owner), the computed result (requester 1) and the error/status code (requester 2). The block sits directly upstream of `seven_seg_fsm` and drives its `input_number` and `mode` inputs. Event requesters (1, 2) get a guaranteed minimum on-screen time and round-robin fairness; requester 0 owns the display whenever no event requester does.

---
 rtl/display_arbiter.sv | 151 +++++++++++++++
 tb/tb_display_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/display_arbiter.sv
// Shares one seven-segment display driver among a background owner and two event requesters.
// Optional error blink on requester 2 is built only when DISP_ARB_BLINK_EN is defined.
module display_arbiter #(
    parameter int unsigned HOLD_CYCLES  = 100000000,
    parameter int unsigned BLINK_CYCLES = 25000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [31:0] value0,
    input  logic [31:0] value1,
    input  logic [31:0] value2,
    input  logic        mode0,
    input  logic        mode1,
    input  logic        mode2,
    output logic [2:0]  grant,
    output logic [31:0] input_number,
    output logic        mode,
    output logic        busy,
    output logic        blank
);

    typedef enum logic [1:0] {
        S_DEFAULT,
        S_HOLD,
        S_OWN
    } state_t;

    if (HOLD_CYCLES < 1 || BLINK_CYCLES < 1) begin : g_bad_params
        $error("display_arbiter: HOLD_CYCLES and BLINK_CYCLES must be at least 1");
    end

    state_t      state;
    state_t      nxt_state;
    logic [1:0]  owner;      // 1 or 2 while busy, 0 in DEFAULT
    logic [1:0]  nxt_owner;
    logic [1:0]  rr;         // preferred event requester, 1 or 2
    logic [31:0] hold_cnt;
    logic        take;       // a new event grant starts this edge
    logic [1:0]  other;
    logic [1:0]  alt;
    logic [1:0]  winner;

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        nxt_state = state;
        nxt_owner = owner;
        take      = 1'b0;
        other     = (owner == 2'd1) ? 2'd2 : 2'd1;
        alt       = (rr == 2'd1) ? 2'd2 : 2'd1;
        winner    = req[rr] ? rr : alt;
        case (state)
            S_DEFAULT: begin
                if (req[1] | req[2]) begin
                    take      = 1'b1;
                    nxt_state = S_HOLD;
                    nxt_owner = winner;
                end
            end
            S_HOLD: begin
                if (hold_cnt == 32'd0) begin
                    if (req[other]) begin
                        take      = 1'b1;
                        nxt_owner = other;
                    end else if (req[owner]) begin
                        nxt_state = S_OWN;
                    end else begin
                        nxt_state = S_DEFAULT;
                        nxt_owner = 2'd0;
                    end
                end
            end
            S_OWN: begin
                if (req[other]) begin
                    take      = 1'b1;
                    nxt_state = S_HOLD;
                    nxt_owner = other;
                end else if (!req[owner]) begin
                    nxt_state = S_DEFAULT;
                    nxt_owner = 2'd0;
                end
            end
            default: begin
                nxt_state = S_DEFAULT;
                nxt_owner = 2'd0;
            end
        endcase
    end

    // Outputs are registered from the next-state decision, giving one-cycle request latency.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_DEFAULT;
            owner        <= 2'd0;
            rr           <= 2'd1;
            hold_cnt     <= 32'd0;
            grant        <= 3'b000;
            input_number <= 32'd0;
            mode         <= 1'b0;
            busy         <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state <= nxt_state;
            owner <= nxt_owner;
            if (take) begin
                hold_cnt <= HOLD_CYCLES - 32'd1;
                rr       <= (nxt_owner == 2'd1) ? 2'd2 : 2'd1;
            end else if (state == S_HOLD && hold_cnt != 32'd0) begin
                hold_cnt <= hold_cnt - 32'd1;
            end
            if (nxt_state == S_DEFAULT) begin
                grant        <= {2'b00, req[0]};
                input_number <= value0;
                mode         <= mode0;
                busy         <= 1'b0;
            end else begin
                grant        <= 3'b001 << nxt_owner;
                input_number <= (nxt_owner == 2'd2) ? value2 : value1;
                mode         <= (nxt_owner == 2'd2) ? mode2 : mode1;
                busy         <= 1'b1;
            end
        end
    end

`ifdef DISP_ARB_BLINK_EN
    logic [31:0] blink_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            blank     <= 1'b0;
            blink_cnt <= 32'd0;
        end else if (nxt_state != S_DEFAULT && nxt_owner == 2'd2) begin
            if (take) begin
                blank     <= 1'b0;
                blink_cnt <= BLINK_CYCLES - 32'd1;
            end else if (blink_cnt == 32'd0) begin
                blank     <= ~blank;
                blink_cnt <= BLINK_CYCLES - 32'd1;
            end else begin
                blink_cnt <= blink_cnt - 32'd1;
            end
        end else begin
            blank     <= 1'b0;
            blink_cnt <= 32'd0;
        end
    end
`else
    assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with HOLD_CYCLES = 4 and BLINK_CYCLES = 2.
module tb_display_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  req = 3'b000;
    logic [31:0] value0 = 32'd0, value1 = 32'd0, value2 = 32'd0;
    logic        mode0 = 1'b0, mode1 = 1'b0, mode2 = 1'b0;
    logic [2:0]  grant;
    logic [31:0] input_number;
    logic        mode, busy, blank;

    int vectors = 0;
    int miscompares = 0;

    display_arbiter #(.HOLD_CYCLES(4), .BLINK_CYCLES(2)) dut (
        .clock(clock), .reset(reset), .req(req),
        .value0(value0), .value1(value1), .value2(value2),
        .mode0(mode0), .mode1(mode1), .mode2(mode2),
        .grant(grant), .input_number(input_number), .mode(mode),
        .busy(busy), .blank(blank)
    );

    always #5 clock = ~clock;

    // Advance one edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 3'b000;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        value0 = 32'h1234; mode0 = 1'b1;
        value1 = 32'd1; value2 = 32'd2;
        reset = 1'b1;
        req   = 3'b111;
        tick();
        vectors++;
        if ({grant, busy, mode, blank} !== 6'b000000 || input_number !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_state got grant=%b busy=%b mode=%b blank=%b num=%h exp all zero",
                     grant, busy, mode, blank, input_number);
        end
        reset = 1'b0;
        req   = 3'b001;
        tick();
        vectors++;
        if (grant !== 3'b001 || input_number !== 32'h1234 || mode !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL default_owner got grant=%b num=%h mode=%b busy=%b exp 001/1234/1/0",
                     grant, input_number, mode, busy);
        end
    endtask

    task automatic test_pulse();
        logic [31:0] exp_v;
        value1 = 32'd99; mode1 = 1'b0;
        exp_v  = 32'd99;
        req    = 3'b011;
        tick();
        req    = 3'b001;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (grant !== 3'b010 || input_number !== exp_v || busy !== 1'b1 || mode !== 1'b0) begin
                miscompares++;
                $display("FAIL pulse_hold cyc=%0d got grant=%b num=%0d busy=%b exp 010/%0d/1",
                         i, grant, input_number, busy, exp_v);
            end
            if (i == 1) value1 = 32'd100;
            tick();
            if (i == 1) exp_v = 32'd100;
        end
        vectors++;
        if (grant !== 3'b001 || busy !== 1'b0 || input_number !== 32'h1234) begin
            miscompares++;
            $display("FAIL pulse_release got grant=%b busy=%b num=%h exp 001/0/1234",
                     grant, busy, input_number);
        end
        // Requester 1 last won, so requester 2 is now preferred.
        value2 = 32'd22;
        req    = 3'b111;
        tick();
        vectors++;
        if (grant !== 3'b100 || input_number !== 32'd22) begin
            miscompares++;
            $display("FAIL rr_from_default got grant=%b num=%0d exp 100/22", grant, input_number);
        end
        req = 3'b000;
        for (int i = 0; i < 4; i++) tick();
        vectors++;
        if (grant !== 3'b000 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rr_release got grant=%b busy=%b exp 000/0", grant, busy);
        end
    endtask

    task automatic test_simultaneous();
        logic [2:0]  exp_g;
        logic [31:0] exp_v;
        do_reset();
        value1 = 32'd11; value2 = 32'd22;
        req    = 3'b111;
        tick();
        for (int c = 0; c < 10; c++) begin
            exp_g = (c < 4 || c >= 8) ? 3'b010 : 3'b100;
            exp_v = (exp_g == 3'b010) ? 32'd11 : 32'd22;
            vectors++;
            if (grant !== exp_g || input_number !== exp_v || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL simultaneous cyc=%0d got grant=%b num=%0d busy=%b exp %b/%0d/1",
                         c, grant, input_number, busy, exp_g, exp_v);
            end
            tick();
        end
        req = 3'b000;
    endtask

    task automatic test_own();
        logic exp_b;
        do_reset();
        value1 = 32'd7; value2 = 32'd5; mode2 = 1'b1;
        req    = 3'b100;
        tick();
        for (int k = 0; k < 10; k++) begin
`ifdef DISP_ARB_BLINK_EN
            exp_b = ((k / 2) % 2) == 1;
`else
            exp_b = 1'b0;
`endif
            vectors++;
            if (grant !== 3'b100 || busy !== 1'b1 || mode !== 1'b1 || input_number !== 32'd5 || blank !== exp_b) begin
                miscompares++;
                $display("FAIL own_hold cyc=%0d got grant=%b busy=%b mode=%b num=%0d blank=%b exp 100/1/1/5/%b",
                         k, grant, busy, mode, input_number, blank, exp_b);
            end
            tick();
        end
        req = 3'b110;
        tick();
        vectors++;
        if (grant !== 3'b010 || input_number !== 32'd7 || blank !== 1'b0) begin
            miscompares++;
            $display("FAIL own_preempt got grant=%b num=%0d blank=%b exp 010/7/0", grant, input_number, blank);
        end
        // Owner drops its request during HOLD: the full grant is still served.
        req = 3'b000;
        for (int k = 1; k < 4; k++) begin
            tick();
            vectors++;
            if (grant !== 3'b010 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL drop_in_hold cyc=%0d got grant=%b busy=%b exp 010/1", k, grant, busy);
            end
        end
        tick();
        vectors++;
        if (grant !== 3'b000 || busy !== 1'b0 || blank !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_release got grant=%b busy=%b blank=%b exp 000/0/0", grant, busy, blank);
        end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        value1 = 32'd7;
        req    = 3'b010;
        tick();
        tick();
        vectors++;
        if (grant !== 3'b010) begin
            miscompares++;
            $display("FAIL mid_hold_setup got grant=%b exp 010", grant);
        end
        reset = 1'b1;
        tick();
        vectors++;
        if (grant !== 3'b000 || input_number !== 32'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_hold_reset got grant=%b num=%0d busy=%b exp 000/0/0", grant, input_number, busy);
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (grant !== 3'b010 || input_number !== 32'd7 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL after_reset got grant=%b num=%0d busy=%b exp 010/7/1", grant, input_number, busy);
        end
        req = 3'b000;
    endtask

    initial begin
        test_reset();
        test_pulse();
        test_simultaneous();
        test_own();
        test_reset_mid_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
